rca_checker: RTL and testbench
==============================

# rca_checker

Synthesizable response checker for the 8-bit ripple-carry adder: the receiving end of the adder's operand/result interface. It samples each applied vector (a, b, cin) together with the adder's sum and cout, and compares them against a built-in golden add. It counts vectors and mismatches, captures the first failing vector, and reports pass/fail when a programmed number of vectors has been checked. It sits beside the rca in on-chip self-test and in benches, replacing eyeball inspection of monitor logs.

## Interface
- NVEC, 65536: number of vectors in one checking session (256*256 = exhaustive a×b sweep); legal range 1..65536.
- CW, 17: counter width; must satisfy 2^CW > NVEC.

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a session; clears counters
- vec_valid  in  1  a/b/cin/sum/cout hold a valid sample this cycle
- a, b  in  8  operands applied to the rca
- cin  in  1  carry-in applied to the rca
- sum  in  8  rca sum output
- cout  in  1  rca carry output
- busy  out  1  session in progress (RUN or DRAIN)
- done  out  1  session complete; held until next start or rst
- pass  out  1  valid with done; 1 when err_count = 0
- vec_count  out  CW  vectors accepted this session
- err_count  out  CW  mismatching vectors this session
- ff_valid  out  1  first-failure capture holds data
- ff_a, ff_b  out  8  operands of first failing vector
- ff_cin  out  1  cin of first failing vector
- ff_sum  out  9  observed {cout,sum} of first failing vector

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0.
- IDLE/DONE + start: clear vec_count, err_count, ff_*; -> RUN. done and pass drop on the same edge.
- RUN: each cycle with vec_valid=1 registers {a,b,cin,cout,sum} into stage S1 and increments vec_count. The edge accepting vector NVEC moves to DRAIN.
- S1 compare, one edge later: expected = {1'b0,a} + {1'b0,b} + cin, 9-bit result, no truncation. Mismatch when expected ≠ {cout,sum}; increments err_count.
- First mismatch only (ff_valid=0): load ff_* and set ff_valid. Later mismatches do not overwrite.
- DRAIN: one cycle, retires the last S1 compare; -> DONE.
- DONE: done=1, pass=(err_count==0); outputs hold.
- vec_valid outside RUN is ignored. No counting or compare occurs.
- start in RUN or DRAIN is ignored; the session is not restarted.
- Counters cannot wrap: vec_count stops at NVEC by construction, and err_count ≤ vec_count.
- rst at any time, including mid-RUN: immediate return to IDLE with all outputs 0. The partial session is discarded.

## Timing
- Accept latency: vec_count updates at the edge sampling vec_valid.
- Check latency: err_count and ff_* update one edge after sampling, because of the S1 register.
- Completion: last vector sampled at edge N; DRAIN during N..N+1; done=1 after edge N+1, with final err_count already visible.
- Back-to-back vec_valid every cycle is supported; no backpressure. Gaps are allowed.
- busy=1 from the start edge through the DRAIN cycle.

## Configuration
- RCA_CHECKER_FAILCAP_EN defined: ff_valid, ff_a, ff_b, ff_cin and ff_sum registers are built as described.
- Not defined: capture registers are omitted and the ff_* ports are driven constant 0. Counting, pass/fail and timing are unchanged.

## Structure
- Package rca_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - RCA_W = 8
  - RCA_SUM_W = 9
  - default NVEC
- Sub-module rca_golden: combinational 8-bit add with carry-in, producing a 9-bit expected result. Instantiated once at stage S1; reusable by the rca bench.

## Test plan
- Reset: assert rst mid-cycle -> busy=done=pass=0, counters=0, ff_valid=0 without waiting for clk.
- Clean stream, NVEC=16: start, then vectors {a,b}=i for i=0..15, cin=0, correct sums -> vec_count=16, err_count=0, done and pass =1 one edge after the last sample.
- Injected error, NVEC=16: vector a=0, b=5 driven with sum=06 -> err_count=1, pass=0, ff_a=00, ff_b=05, ff_cin=0, ff_sum=006. A second error later does not change ff_*.
- Carry boundary: a=FF, b=01, cin=0 with {cout,sum}=1_00 -> no error. a=FF, b=FF, cin=1 with cout=0, sum=FF -> error, expected 1_FF.
- Gaps and ignores: vec_valid toggled 1/0 during RUN -> only high cycles counted. vec_valid in DONE and start in RUN -> no effect.
- Reset mid-RUN after 7 vectors, then start -> fresh session counts from 0 and completes normally. Repeat with RCA_CHECKER_FAILCAP_EN undefined -> ff_* stay 0 throughout.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types and constants for the rca response checker and its golden adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rca_pkg;

  // Operand width of the ripple-carry adder under test
  localparam int RCA_W = 8;

  // Width of {cout,sum}; one bit wider than the operands so nothing is truncated
  localparam int RCA_SUM_W = 9;

  // Default session length: exhaustive a x b sweep
  localparam int NVEC_DEFAULT = 65536;

  // Default counter width; 2^CW must exceed NVEC so a full session never wraps
  localparam int CW_DEFAULT = 17;

  // Checker session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rca_golden.sv
// Golden reference add: {1'b0,a} + {1'b0,b} + cin as a full 9-bit result.
// Latency: purely combinational.
// Backpressure: none.
module rca_golden
  import rca_pkg::*;
(
  input  logic [RCA_W-1:0]     a_i,
  input  logic [RCA_W-1:0]     b_i,
  input  logic                 cin_i,
  output logic [RCA_SUM_W-1:0] exp_o
);

  // Zero-extend both operands and the carry so the carry-out lands in bit 8
  assign exp_o = {1'b0, a_i} + {1'b0, b_i} + {{(RCA_SUM_W-1){1'b0}}, cin_i};

endmodule

// File: rtl/rca_checker.sv
// Response checker for the 8-bit rca: counts vectors/mismatches, reports pass/fail; optional first-failure capture under RCA_CHECKER_FAILCAP_EN.
// Latency: vec_count on the accepting edge, err_count/ff_* one edge later, done one edge after the last accept.
// Backpressure: none; a vector may arrive every cycle during RUN, and vec_valid outside RUN is ignored.
module rca_checker
  import rca_pkg::*;
#(
  parameter int NVEC = NVEC_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [RCA_W-1:0]     a,
  input  logic [RCA_W-1:0]     b,
  input  logic                 cin,
  input  logic [RCA_W-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CW-1:0]        vec_count,
  output logic [CW-1:0]        err_count,
  output logic                 ff_valid,
  output logic [RCA_W-1:0]     ff_a,
  output logic [RCA_W-1:0]     ff_b,
  output logic                 ff_cin,
  output logic [RCA_SUM_W-1:0] ff_sum
);

  // Count value held just before the edge that accepts the final vector
  localparam logic [CW-1:0] LAST_CNT = CW'(NVEC - 1);

  // Session state and registered status outputs
  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [CW-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d;

  // Stage S1: one accepted vector waiting to be compared on the next edge
  logic                 s1_vld_q, s1_vld_d;
  logic [RCA_W-1:0]     s1_a_q, s1_a_d;
  logic [RCA_W-1:0]     s1_b_q, s1_b_d;
  logic                 s1_cin_q, s1_cin_d;
  logic [RCA_SUM_W-1:0] s1_obs_q, s1_obs_d;

  logic [RCA_SUM_W-1:0] s1_exp;
  logic                 s1_mis;
  logic                 sess_clr;

  // Golden result for the vector currently held in S1
  rca_golden u_golden (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .cin_i (s1_cin_q),
    .exp_o (s1_exp)
  );

  // A mismatch only counts when S1 holds a real vector
  assign s1_mis = s1_vld_q && (s1_exp != s1_obs_q);

  // A new session may only be opened from IDLE or DONE
  assign sess_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state logic: session sequencing, accept counting and S1 loading
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    s1_vld_d  = 1'b0;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_cin_d  = s1_cin_q;
    s1_obs_d  = s1_obs_q;

    // The S1 compare retires independently of what the FSM does this edge
    if (s1_mis) begin
      err_cnt_d = err_cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sess_clr) begin
          state_d   = ST_RUN;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          vec_cnt_d = '0;
          err_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (vec_valid) begin
          s1_vld_d  = 1'b1;
          s1_a_d    = a;
          s1_b_d    = b;
          s1_cin_d  = cin;
          s1_obs_d  = {cout, sum};
          vec_cnt_d = vec_cnt_q + CW'(1);
          if (vec_cnt_q == LAST_CNT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last S1 compare retires on this edge, so judge on its result
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_d == '0);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Session state, counters, status outputs and stage S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_cin_q  <= 1'b0;
      s1_obs_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_cin_q  <= s1_cin_d;
      s1_obs_q  <= s1_obs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign vec_count = vec_cnt_q;
  assign err_count = err_cnt_q;

`ifdef RCA_CHECKER_FAILCAP_EN
  // First-failure capture: loads once per session, later mismatches are dropped
  logic                 ff_vld_q, ff_vld_d;
  logic [RCA_W-1:0]     ff_a_q, ff_a_d;
  logic [RCA_W-1:0]     ff_b_q, ff_b_d;
  logic                 ff_cin_q, ff_cin_d;
  logic [RCA_SUM_W-1:0] ff_sum_q, ff_sum_d;

  // Capture next-state: clear on a new session, else latch the first mismatch
  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_a_d   = ff_a_q;
    ff_b_d   = ff_b_q;
    ff_cin_d = ff_cin_q;
    ff_sum_d = ff_sum_q;
    if (sess_clr) begin
      ff_vld_d = 1'b0;
      ff_a_d   = '0;
      ff_b_d   = '0;
      ff_cin_d = 1'b0;
      ff_sum_d = '0;
    end else if (s1_mis && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_a_d   = s1_a_q;
      ff_b_d   = s1_b_q;
      ff_cin_d = s1_cin_q;
      ff_sum_d = s1_obs_q;
    end
  end

  // Capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld_q <= 1'b0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_cin_q <= 1'b0;
      ff_sum_q <= '0;
    end else begin
      ff_vld_q <= ff_vld_d;
      ff_a_q   <= ff_a_d;
      ff_b_q   <= ff_b_d;
      ff_cin_q <= ff_cin_d;
      ff_sum_q <= ff_sum_d;
    end
  end

  assign ff_valid = ff_vld_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_cin   = ff_cin_q;
  assign ff_sum   = ff_sum_q;
`else
  // Capture not built: ports tie off, counting and pass/fail are unaffected
  assign ff_valid = 1'b0;
  assign ff_a     = '0;
  assign ff_b     = '0;
  assign ff_cin   = 1'b0;
  assign ff_sum   = '0;
`endif

endmodule

// File: tb/tb_rca_checker.sv
// Bench for rca_checker with a short session (NVEC=16): session-level model plus literal spot checks.
// Inputs change one time unit after the rising edge; outputs are compared at the same point.
// Works with or without RCA_CHECKER_FAILCAP_EN (capture expectations follow the macro).
module tb_rca_checker;

  localparam int NV  = 16;
  localparam int CWT = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           vec_valid = 1'b0;
  logic [7:0]     a = '0;
  logic [7:0]     b = '0;
  logic           cin = 1'b0;
  logic [7:0]     sum = '0;
  logic           cout = 1'b0;
  logic           busy, done, pass;
  logic [CWT-1:0] vec_count, err_count;
  logic           ff_valid;
  logic [7:0]     ff_a, ff_b;
  logic           ff_cin;
  logic [8:0]     ff_sum;

  rca_checker #(.NVEC(NV), .CW(CWT)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin), .ff_sum(ff_sum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Session-level model: phase, counts and a single pending (accepted, not yet judged) vector
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
  int       m_phase;
  bit       m_busy, m_done, m_pass;
  int       m_vec, m_err;
  bit       m_pend;
  bit [7:0] p_a, p_b;
  bit       p_cin;
  bit [8:0] p_obs;
  bit       m_ffv;
  bit [7:0] m_ffa, m_ffb;
  bit       m_ffcin;
  bit [8:0] m_ffsum;

  function automatic bit [8:0] add9(input bit [7:0] x, input bit [7:0] y, input bit c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return 9'(s);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_busy = 0; m_done = 0; m_pass = 0;
    m_vec = 0; m_err = 0; m_pend = 0;
    m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffcin = 0; m_ffsum = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge
  task automatic model_edge();
    if (m_pend) begin
      if (add9(p_a, p_b, p_cin) != p_obs) begin
        m_err++;
`ifdef RCA_CHECKER_FAILCAP_EN
        if (!m_ffv) begin
          m_ffv = 1; m_ffa = p_a; m_ffb = p_b; m_ffcin = p_cin; m_ffsum = p_obs;
        end
`endif
      end
      m_pend = 0;
    end
    if ((m_phase == P_IDLE || m_phase == P_DONE) && start) begin
      m_phase = P_RUN; m_busy = 1; m_done = 0; m_pass = 0;
      m_vec = 0; m_err = 0;
      m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffcin = 0; m_ffsum = 0;
    end else if (m_phase == P_RUN && vec_valid) begin
      m_pend = 1; p_a = a; p_b = b; p_cin = cin; p_obs = {cout, sum};
      m_vec++;
      if (m_vec == NV) m_phase = P_DRAIN;
    end else if (m_phase == P_DRAIN) begin
      m_phase = P_DONE; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
    end
  endtask

  task automatic compare_all();
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("pass", int'(pass), int'(m_pass));
    chk("vec_count", int'(vec_count), m_vec);
    chk("err_count", int'(err_count), m_err);
    chk("ff_valid", int'(ff_valid), int'(m_ffv));
    chk("ff_a", int'(ff_a), int'(m_ffa));
    chk("ff_b", int'(ff_b), int'(m_ffb));
    chk("ff_cin", int'(ff_cin), int'(m_ffcin));
    chk("ff_sum", int'(ff_sum), int'(m_ffsum));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input int x, input int y, input bit c, input bit [8:0] obs);
    a = 8'(x); b = 8'(y); cin = c; {cout, sum} = obs;
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
  endtask

  task automatic drive_ok(input int x, input int y, input bit c);
    drive(x, y, c, add9(8'(x), 8'(y), c));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Capture expectations depend on whether the capture is built
  task automatic chk_ff_lit(input string tag, input int ea, input int eb, input int ec, input int es);
`ifdef RCA_CHECKER_FAILCAP_EN
    chk({tag, "_ffv_lit"}, int'(ff_valid), 1);
    chk({tag, "_ffa_lit"}, int'(ff_a), ea);
    chk({tag, "_ffb_lit"}, int'(ff_b), eb);
    chk({tag, "_ffcin_lit"}, int'(ff_cin), ec);
    chk({tag, "_ffsum_lit"}, int'(ff_sum), es);
`else
    chk({tag, "_ffv_lit"}, int'(ff_valid), 0);
    chk({tag, "_ffa_lit"}, int'(ff_a), 0 * ea);
    chk({tag, "_ffb_lit"}, int'(ff_b), 0 * eb);
    chk({tag, "_ffcin_lit"}, int'(ff_cin), 0 * ec);
    chk({tag, "_ffsum_lit"}, int'(ff_sum), 0 * es);
`endif
  endtask

  initial begin
    model_reset();
    // Reset asserted between edges must clear outputs without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_lit", int'(busy), 0);
    chk("rst_done_lit", int'(done), 0);
    chk("rst_vec_lit", int'(vec_count), 0);
    compare_all();
    idle(2);
    #3 rst = 1'b0;
    idle(2);

    // Clean stream: a=b=i, cin=0, correct sums
    do_start();
    chk("start_busy_lit", int'(busy), 1);
    for (int i = 0; i < NV; i++) drive_ok(i, i, 1'b0);
    chk("clean_vec_lit", int'(vec_count), 16);
    chk("clean_drain_busy_lit", int'(busy), 1);
    chk("clean_drain_done_lit", int'(done), 0);
    step();
    chk("clean_done_lit", int'(done), 1);
    chk("clean_pass_lit", int'(pass), 1);
    chk("clean_err_lit", int'(err_count), 0);
    chk("clean_busy_lit", int'(busy), 0);
    // vec_valid in DONE is ignored, even with a wrong sum
    drive(1, 2, 1'b0, 9'h000);
    idle(1);
    chk("done_ignore_vec_lit", int'(vec_count), 16);
    chk("done_ignore_err_lit", int'(err_count), 0);

    // Injected errors, carry boundary, gaps and start-in-RUN
    do_start();
    chk("restart_done_lit", int'(done), 0);
    chk("restart_vec_lit", int'(vec_count), 0);
    drive(0, 5, 1'b0, 9'h006);
    chk("err_before_check_lit", int'(err_count), 0);
    idle(1);
    chk("err_after_check_lit", int'(err_count), 1);
    chk_ff_lit("first", 8'h00, 8'h05, 0, 9'h006);
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_run_vec_lit", int'(vec_count), 1);
    drive(8'hFF, 8'h01, 1'b0, 9'h100);
    drive(8'hFF, 8'hFF, 1'b1, 9'h0FF);
    drive_ok(3, 4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive_ok(i * 7, i * 3 + 1, i[0]);
      if (i[1]) idle(1);
    end
    chk("err_drain_vec_lit", int'(vec_count), 16);
    step();
    chk("err_done_lit", int'(done), 1);
    chk("err_pass_lit", int'(pass), 0);
    chk("err_count_lit", int'(err_count), 2);
    chk_ff_lit("kept", 8'h00, 8'h05, 0, 9'h006);

    // Reset mid-RUN after 7 vectors, then a fresh session
    do_start();
    for (int i = 0; i < 7; i++) drive_ok(i + 100, i, 1'b1);
    chk("mid_vec_lit", int'(vec_count), 7);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_busy_lit", int'(busy), 0);
    chk("mid_rst_vec_lit", int'(vec_count), 0);
    compare_all();
    #1 rst = 1'b0;
    idle(1);
    do_start();
    for (int i = 0; i < NV; i++) begin
      if (i == 9) drive(9, 9, 1'b0, 9'h013);
      else drive_ok(i * 11, 255 - i, 1'b0);
    end
    step();
    chk("fresh_done_lit", int'(done), 1);
    chk("fresh_vec_lit", int'(vec_count), 16);
    chk("fresh_err_lit", int'(err_count), 1);
    chk("fresh_pass_lit", int'(pass), 0);
    chk_ff_lit("fresh", 8'h09, 8'h09, 0, 9'h013);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
